// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS subset core sharing one instruction/data memory port
// through a req/ack handshake that tolerates any memory latency.
module mips_multicycle_core #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          ADDR_W     = 32,
  parameter bit          ENABLE_BNE = 1'b1,
  parameter bit          ENABLE_JAL = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              halted,
  output logic              illegal_op,
  output logic [31:0]       dbg_pc
);

  // state  | meaning
  // FETCH  | read instruction at PC; on ack latch IR and advance PC
  // DECODE | latch A/B and branch target; reject undecodable encodings
  // EXEC   | ALU op, effective address, branch/jump resolution
  // MEM    | lw read or sw write at ALUOut
  // WB     | register file write-back
  // HALT   | stopped, left only by reset
  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  state_t            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic [31:0]       alu_q, alu_d;
  logic [31:0]       mdr_q, mdr_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              halted_q, halted_d;
  logic              ill_q, ill_d;
  logic [31:0]       rf_q [32];

  logic              rf_we;
  logic [4:0]        rf_waddr;
  logic [31:0]       rf_wdata;

  logic [5:0]        opcode, funct;
  logic [4:0]        rs, rt, rd;
  logic [31:0]       imm_sx, ea, jump_tgt, br_pc, alu_r;
  logic              op_legal, branch_taken;
  logic              unused_shamt;

  assign opcode       = ir_q[31:26];
  assign rs           = ir_q[25:21];
  assign rt           = ir_q[20:16];
  assign rd           = ir_q[15:11];
  assign funct        = ir_q[5:0];
  assign unused_shamt = ^ir_q[10:6];
  assign imm_sx       = {{16{ir_q[15]}}, ir_q[15:0]};
  assign ea           = a_q + imm_sx;
  assign jump_tgt     = {pc_q[31:28], ir_q[25:0], 2'b00};
  assign branch_taken = (opcode == OP_BNE) ? (a_q != b_q) : (a_q == b_q);
  assign br_pc        = branch_taken ? alu_q : pc_q;

  // Truncate to the port width and force word alignment.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [31:0] v);
    logic [ADDR_W-1:0] a;
    a      = v[ADDR_W-1:0];
    a[1:0] = 2'b00;
    return a;
  endfunction

  always_comb begin
    op_legal = 1'b0;
    case (opcode)
      OP_RTYPE: op_legal = funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
      OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: op_legal = 1'b1;
      OP_BNE:   op_legal = ENABLE_BNE;
      OP_JAL:   op_legal = ENABLE_JAL;
      default:  op_legal = 1'b0;
    endcase
  end

  always_comb begin
    alu_r = a_q + b_q;
    case (funct)
      FN_SUB:  alu_r = a_q - b_q;
      FN_AND:  alu_r = a_q & b_q;
      FN_OR:   alu_r = a_q | b_q;
      FN_SLT:  alu_r = {31'd0, $signed(a_q) < $signed(b_q)};
      default: alu_r = a_q + b_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    alu_d    = alu_q;
    mdr_d    = mdr_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    halted_d = halted_q;
    ill_d    = 1'b0;
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = 32'd0;

    case (state_q)
      S_FETCH: begin
        // Only reachable with req low straight after reset.
        if (!req_q) begin
          req_d  = 1'b1;
          we_d   = 1'b0;
          addr_d = word_addr(pc_q);
        end else if (mem_ack) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + 32'd4;
          req_d   = 1'b0;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d   = rf_q[rs];
        b_d   = rf_q[rt];
        alu_d = pc_q + (imm_sx << 2);
        if (!op_legal) begin
          ill_d    = 1'b1;
          halted_d = 1'b1;
          state_d  = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (opcode)
          OP_RTYPE: begin
            alu_d   = alu_r;
            state_d = S_WB;
          end
          OP_ADDI: begin
            alu_d   = ea;
            state_d = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_d   = ea;
            req_d   = 1'b1;
            we_d    = (opcode == OP_SW);
            addr_d  = word_addr(ea);
            wdata_d = b_q;
            state_d = S_MEM;
          end
          OP_BEQ, OP_BNE: begin
            pc_d    = br_pc;
            req_d   = 1'b1;
            we_d    = 1'b0;
            addr_d  = word_addr(br_pc);
            state_d = S_FETCH;
          end
          OP_J, OP_JAL: begin
            pc_d     = jump_tgt;
            req_d    = 1'b1;
            we_d     = 1'b0;
            addr_d   = word_addr(jump_tgt);
            state_d  = S_FETCH;
            rf_we    = (opcode == OP_JAL);
            rf_waddr = 5'd31;
            rf_wdata = pc_q;
          end
          default: begin
            halted_d = 1'b1;
            state_d  = S_HALT;
          end
        endcase
      end
      S_MEM: begin
        if (mem_ack) begin
          if (we_q) begin
            req_d   = 1'b1;
            we_d    = 1'b0;
            addr_d  = word_addr(pc_q);
            state_d = S_FETCH;
          end else begin
            mdr_d   = mem_rdata;
            req_d   = 1'b0;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we = 1'b1;
        case (opcode)
          OP_RTYPE: begin rf_waddr = rd; rf_wdata = alu_q; end
          OP_LW:    begin rf_waddr = rt; rf_wdata = mdr_q; end
          default:  begin rf_waddr = rt; rf_wdata = alu_q; end
        endcase
        req_d   = 1'b1;
        we_d    = 1'b0;
        addr_d  = word_addr(pc_q);
        state_d = S_FETCH;
      end
      S_HALT: begin
        req_d    = 1'b0;
        halted_d = 1'b1;
      end
      default: begin
        req_d    = 1'b0;
        halted_d = 1'b1;
        state_d  = S_HALT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      alu_q    <= '0;
      mdr_q    <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      halted_q <= 1'b0;
      ill_q    <= 1'b0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      alu_q    <= alu_d;
      mdr_q    <= mdr_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      halted_q <= halted_d;
      ill_q    <= ill_d;
      if (rf_we && rf_waddr != 5'd0) rf_q[rf_waddr] <= rf_wdata;
    end
  end

  assign mem_req    = req_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign halted     = halted_q;
  assign illegal_op = ill_q;
  assign dbg_pc     = pc_q;

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Scoreboard bench: stimulus loads programs and queues expected memory
// transfers; the memory responder pops and compares at every handshake.
module tb_mips_multicycle_core;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    int          gap;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        halted, illegal_op;
  logic [31:0] dbg_pc;

  logic        nj_req, nj_we, nj_halted, nj_ill;
  logic [31:0] nj_addr, nj_wdata, nj_pc;

  exp_t        exp_q[$];
  logic [31:0] mem [512];
  int          checks;
  int          errors;
  int          ack_delay;
  int          cyc;
  int          last_hs;
  int          ill_cnt;
  int          nj_ill_cnt;

  logic [31:0] t1_data [6] = '{32'd2, 32'd1, 32'd8, 32'd5, 32'hFFFF_FFFD, 32'd0};

  mips_multicycle_core dut (
    .clk        (clk),
    .reset      (reset),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .halted     (halted),
    .illegal_op (illegal_op),
    .dbg_pc     (dbg_pc)
  );

  // Second core with jal disabled, fed a jal on every fetch with zero-wait ack.
  mips_multicycle_core #(.ENABLE_JAL(1'b0)) dut_nj (
    .clk        (clk),
    .reset      (reset),
    .mem_req    (nj_req),
    .mem_we     (nj_we),
    .mem_addr   (nj_addr),
    .mem_wdata  (nj_wdata),
    .mem_rdata  (32'h0C00_0040),
    .mem_ack    (nj_req),
    .halted     (nj_halted),
    .illegal_op (nj_ill),
    .dbg_pc     (nj_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req_v);
    end
  endtask

  task automatic push(input logic we, input logic [31:0] addr, input logic [31:0] data,
                      input int gap);
    exp_t e;
    e.we = we; e.addr = addr; e.data = data; e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic load(input logic [31:0] addr, input logic [31:0] w);
    mem[addr[10:2]] = w;
  endtask

  task automatic start_test(input int dly);
    @(negedge clk);
    reset = 1'b0;
    ack_delay = dly;
    for (int i = 0; i < 512; i++) mem[i] = 32'hFC00_0000;
  endtask

  task automatic release_reset();
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic reset_checks(input string tag);
    #1;
    check({tag, "_rst_req"},    {31'd0, mem_req},    32'd0);
    check({tag, "_rst_we"},     {31'd0, mem_we},     32'd0);
    check({tag, "_rst_addr"},   mem_addr,            32'd0);
    check({tag, "_rst_wdata"},  mem_wdata,           32'd0);
    check({tag, "_rst_halted"}, {31'd0, halted},     32'd0);
    check({tag, "_rst_ill"},    {31'd0, illegal_op}, 32'd0);
    check({tag, "_rst_pc"},     dbg_pc,              32'd0);
  endtask

  task automatic first_fetch(input string tag);
    @(posedge clk);
    #1;
    check({tag, "_first_req"},  {31'd0, mem_req}, 32'd1);
    check({tag, "_first_addr"}, mem_addr,         32'd0);
  endtask

  task automatic finish_test(input string tag, input logic [31:0] pc_exp, input int ill_snap);
    int n;
    int reqs;
    n = 0;
    while (!halted && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_halted"}, {31'd0, halted}, 32'd1);
    reqs = 0;
    repeat (20) begin
      @(negedge clk);
      if (mem_req) reqs++;
    end
    check({tag, "_req_after_halt"}, reqs, 32'd0);
    check({tag, "_halt_pc"}, dbg_pc, pc_exp);
    check({tag, "_ill_pulse_cycles"}, ill_cnt - ill_snap, 32'd1);
    check({tag, "_leftover_expect"}, exp_q.size(), 32'd0);
  endtask

  // Memory responder and scoreboard monitor.
  initial begin
    int          cnt;
    logic [31:0] h_addr, h_wdata;
    logic        h_we;
    exp_t        e;
    cnt = 0;
    mem_ack = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      cyc++;
      if (mem_ack) cnt = 0;
      mem_ack = 1'b0;
      if (mem_req) begin
        if (cnt == 0) begin
          h_addr = mem_addr; h_we = mem_we; h_wdata = mem_wdata;
        end else begin
          check("hold_addr",  mem_addr,         h_addr);
          check("hold_we",    {31'd0, mem_we},  {31'd0, h_we});
          check("hold_wdata", mem_wdata,        h_wdata);
        end
        if (cnt >= ack_delay) begin
          mem_ack = 1'b1;
          if (mem_we) mem[mem_addr[10:2]] = mem_wdata;
          else mem_rdata = mem[mem_addr[10:2]];
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_xfer actual we=%0b addr=%h required none", mem_we, mem_addr);
          end else begin
            e = exp_q.pop_front();
            check("xfer_we",   {31'd0, mem_we}, {31'd0, e.we});
            check("xfer_addr", mem_addr,        e.addr);
            if (e.we) check("xfer_wdata", mem_wdata, e.data);
            if (e.gap > 0) check("xfer_gap", cyc - last_hs, e.gap);
          end
          last_hs = cyc;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (illegal_op) ill_cnt++;
      if (nj_ill) nj_ill_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int   snap;
    int   nj_snap;
    logic found;
    checks = 0; errors = 0; ack_delay = 0; cyc = 0; last_hs = 0;
    ill_cnt = 0; nj_ill_cnt = 0;
    reset = 1'b0;

    // Reset, fetch and arithmetic with zero-wait memory.
    start_test(0);
    snap = ill_cnt;
    nj_snap = nj_ill_cnt;
    load(32'h00, enc_i(6'h08, 5'd0, 5'd1, 16'd5));
    load(32'h04, enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD));
    load(32'h08, enc_r(5'd1, 5'd2, 5'd3, 6'h20));
    load(32'h0C, enc_r(5'd2, 5'd1, 5'd4, 6'h2A));
    load(32'h10, enc_r(5'd1, 5'd2, 5'd5, 6'h22));
    load(32'h14, enc_r(5'd1, 5'd2, 5'd6, 6'h24));
    load(32'h18, enc_r(5'd1, 5'd2, 5'd7, 6'h25));
    load(32'h1C, enc_r(5'd1, 5'd2, 5'd8, 6'h2A));
    for (int k = 0; k < 6; k++)
      load(32'h20 + 32'(4 * k), enc_i(6'h2B, 5'd0, 5'(3 + k), 16'(32'h80 + 4 * k)));
    for (int i = 0; i < 9; i++) push(1'b0, 32'(4 * i), 32'd0, (i == 0) ? 0 : 4);
    for (int k = 0; k < 6; k++) begin
      push(1'b1, 32'h80 + 32'(4 * k), t1_data[k], 3);
      push(1'b0, 32'h24 + 32'(4 * k), 32'd0, 1);
    end
    reset_checks("t1");
    release_reset();
    first_fetch("t1");
    @(posedge clk);
    #1;
    check("t1_pc_after_fetch", dbg_pc, 32'h4);
    finish_test("t1", 32'h3C, snap);
    check("nj_halted", {31'd0, nj_halted}, 32'd1);
    check("nj_ill_pulse_cycles", nj_ill_cnt - nj_snap, 32'd1);
    check("nj_r31", dut_nj.rf_q[31], 32'd0);
    check("nj_pc", nj_pc, 32'h4);

    // Store/load with three wait cycles on every transfer.
    start_test(3);
    snap = ill_cnt;
    load(32'h00, enc_i(6'h08, 5'd0, 5'd3, 16'd2));
    load(32'h04, enc_j(6'h02, 26'h10));
    load(32'h40, enc_i(6'h2B, 5'd0, 5'd3, 16'h8));
    load(32'h44, enc_i(6'h23, 5'd0, 5'd5, 16'h8));
    load(32'h48, enc_i(6'h2B, 5'd0, 5'd5, 16'h84));
    push(1'b0, 32'h00, 32'd0, 0);
    push(1'b0, 32'h04, 32'd0, 7);
    push(1'b0, 32'h40, 32'd0, 6);
    push(1'b1, 32'h08, 32'd2, 6);
    push(1'b0, 32'h44, 32'd0, 4);
    push(1'b0, 32'h08, 32'd0, 6);
    push(1'b0, 32'h48, 32'd0, 5);
    push(1'b1, 32'h84, 32'd2, 6);
    push(1'b0, 32'h4C, 32'd0, 4);
    release_reset();
    finish_test("t2", 32'h50, snap);

    // Branches, jumps and $0 with zero-wait memory.
    start_test(0);
    snap = ill_cnt;
    load(32'h000, enc_i(6'h08, 5'd0, 5'd1, 16'd5));
    load(32'h004, enc_i(6'h08, 5'd0, 5'd0, 16'd7));
    load(32'h008, enc_i(6'h08, 5'd0, 5'd7, 16'd1));
    load(32'h00C, enc_r(5'd1, 5'd7, 5'd8, 6'h20));
    load(32'h010, enc_i(6'h04, 5'd1, 5'd1, 16'd2));
    load(32'h01C, enc_i(6'h05, 5'd1, 5'd1, 16'd5));
    load(32'h020, enc_j(6'h03, 26'h40));
    load(32'h100, enc_i(6'h2B, 5'd0, 5'd31, 16'h80));
    load(32'h104, enc_i(6'h2B, 5'd0, 5'd0, 16'h84));
    load(32'h108, enc_i(6'h05, 5'd1, 5'd0, 16'd1));
    push(1'b0, 32'h000, 32'd0, 0);
    push(1'b0, 32'h004, 32'd0, 4);
    push(1'b0, 32'h008, 32'd0, 4);
    push(1'b0, 32'h00C, 32'd0, 4);
    push(1'b0, 32'h010, 32'd0, 4);
    push(1'b0, 32'h01C, 32'd0, 3);
    push(1'b0, 32'h020, 32'd0, 3);
    push(1'b0, 32'h100, 32'd0, 3);
    push(1'b1, 32'h080, 32'h24, 3);
    push(1'b0, 32'h104, 32'd0, 1);
    push(1'b1, 32'h084, 32'd0, 3);
    push(1'b0, 32'h108, 32'd0, 1);
    push(1'b0, 32'h110, 32'd0, 3);
    release_reset();
    finish_test("t3", 32'h114, snap);

    // Reset asserted during the wait phase of a lw.
    start_test(3);
    load(32'h00, enc_i(6'h08, 5'd0, 5'd5, 16'd9));
    load(32'h04, enc_i(6'h23, 5'd0, 5'd6, 16'h80));
    push(1'b0, 32'h00, 32'd0, 0);
    push(1'b0, 32'h04, 32'd0, 7);
    release_reset();
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      @(posedge clk);
      #2;
      if (mem_req && !mem_we && mem_addr == 32'h80) found = 1'b1;
    end
    check("t4_lw_wait_seen", {31'd0, found}, 32'd1);
    reset = 1'b0;
    reset_checks("t4");
    check("t4_flushed_expect", exp_q.size(), 32'd0);
    snap = ill_cnt;
    ack_delay = 0;
    load(32'h00, enc_i(6'h2B, 5'd0, 5'd5, 16'h84));
    load(32'h04, 32'hFC00_0000);
    push(1'b0, 32'h00, 32'd0, 0);
    push(1'b1, 32'h84, 32'd0, 3);
    push(1'b0, 32'h04, 32'd0, 1);
    release_reset();
    first_fetch("t4");
    finish_test("t4", 32'h08, snap);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_core.md
Name: mips_multicycle_core

Overview:
- Parametrised multi-cycle successor to the single-cycle MIPS top.
- One FSM sequences fetch, decode, execute, memory and writeback over several cycles.
- Uses one shared instruction/data memory port with a req/ack handshake, so the core tolerates variable-latency memory.
- Self-contained: integrates the register file, ALU and PC logic, and adds stall, halt and illegal-instruction detection, which the single-cycle core lacks.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- ADDR_W, 32: width of mem_addr. Byte address is PC/ALU result truncated to the low ADDR_W bits; legal range is 8..32.
- ENABLE_BNE, 1: 1 decodes bne (opcode 6'h05); 0 treats it as illegal.
- ENABLE_JAL, 1: 1 decodes jal (opcode 6'h03, writes PC+4 to $31); 0 treats it as illegal.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-low reset.
- mem_req, output, 1: memory transfer request.
- mem_we, output, 1: 1 = write (sw), 0 = read (fetch/lw).
- mem_addr, output, ADDR_W: byte address, word aligned.
- mem_wdata, output, 32: store data.
- mem_rdata, input, 32: read data, valid in the cycle mem_ack=1.
- mem_ack, input, 1: transfer completes at the clock edge where mem_req=1 and mem_ack=1.
- halted, output, 1: sticky; core stopped.
- illegal_op, output, 1: one-cycle pulse when an undecodable instruction is detected.
- dbg_pc, output, 32: current PC.

Behaviour:
- Reset (reset=0, async) sets:
  - PC=RESET_PC.
  - FSM=FETCH.
  - All 32 registers and IR/A/B/ALUOut/MDR = 0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, halted=0, illegal_op=0.
  - A transfer in flight is abandoned, and a late ack is ignored.
- First request after release: mem_req rises in the first cycle after reset deasserts.
- $0 reads 0; writes to $0 are discarded.
- Handshake:
  - mem_req, mem_we, mem_addr and mem_wdata are registered and held stable until the ack edge.
  - mem_req deasserts in the cycle after ack.
  - Ack may arrive in the first req cycle (zero wait).
  - Ack while mem_req=0 is ignored.
  - No timeout; the core stalls indefinitely.
- FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH:
  - req read at PC.
  - On ack: IR<=mem_rdata, PC<=PC+4 (mod 2^32), go to DECODE.
- DECODE:
  - A<=rf[rs], B<=rf[rt], ALUOut<=PC+(signext(imm)<<2).
  - Illegal opcode, or R-type funct not in {add 20, sub 22, and 24, or 25, slt 2A}: illegal_op=1 for one cycle, go to HALT.
  - Otherwise go to EXEC.
- EXEC:
  - R-type: ALUOut<=A op B, go to WB.
  - lw/sw/addi: ALUOut<=A+signext(imm); lw/sw go to MEM, addi goes to WB.
  - beq (bne): if A==B (A!=B), PC<=ALUOut; go to FETCH.
  - j: PC<={PC[31:28], IR[25:0], 2'b00}; go to FETCH.
  - jal: same PC update as j, plus rf[31]<=PC (already PC+4); go to FETCH.
- MEM:
  - lw: read at ALUOut; on ack MDR<=mem_rdata, go to WB.
  - sw: write B to ALUOut; on ack go to FETCH.
- WB:
  - R-type: rf[rd]<=ALUOut.
  - addi: rf[rt]<=ALUOut.
  - lw: rf[rt]<=MDR.
  - Then go to FETCH.
- Cycle counts with zero-wait memory:
  - R/addi: 4.
  - lw: 5.
  - sw: 4.
  - beq/bne/j/jal: 3.
  - Each wait cycle adds 1.
- Arithmetic: add/sub/addi wrap with no overflow trap. slt is signed, result 1 or 0.
- HALT:
  - halted=1, mem_req=0, PC frozen.
  - Left only by reset.
- Misaligned addresses: low 2 bits are forced to 0 on mem_addr; no fault is raised.

Test Plan:
- Reset/fetch: hold reset=0 for 3 cycles, release, ack immediately → mem_req=1 and mem_addr=0 in the first cycle after release; dbg_pc=4 after the fetch ack.
- Arithmetic: run addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; slt $4,$2,$1 with zero-wait memory → $3=2, $4=1; each instruction takes 4 cycles.
- Memory with waits: ack delayed 3 cycles on every request; sw $3,8($0) then lw $5,8($0) → write seen at address 8 with data 2; $5=2; address/data held stable throughout each wait.
- Branch/jump: beq $1,$1,+2 at PC 0x10 → next fetch at 0x1C. jal 0x40 at 0x20 → next fetch at 0x100, $31=0x24.
- Illegal instruction: fetch 32'hFC00_0000 → illegal_op pulses for exactly 1 cycle, halted=1, no further mem_req. Repeat with ENABLE_JAL=0 fetching a jal → halts and $31 is unchanged.
- Reset mid-operation: assert reset during the MEM wait of lw → mem_req=0 immediately, registers read 0, and the fetch from RESET_PC restarts after release.
